taillight_sequencer: RTL and testbench

- Controller that sequences the six tail-light LEDs of the board-level taillight design: left/right sweeping turn signals, hazard flashing and steady brake overlay.
- Sits between the switch/key decode in the top level and LEDR[5:0]. It also drives a mode code that the top level renders on the HEX displays.
- Owns its own step-rate prescaler, so the top level only supplies ADC_CLK_10 and reset.

---
 rtl/taillight_sequencer.sv | 159 +++++++++++++++
 tb/tb_taillight_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/taillight_sequencer.sv
// taillight_sequencer
//   Sequences the six tail-light LEDs: sweeping left/right turn signals,
//   hazard flashing and a steady brake overlay. Contains its own step-rate
//   prescaler so the top level only supplies the clock and reset.
//
// Parameters
//   TICK_DIV : clock cycles per sequence step (>= 2)
//   CNT_W    : prescaler width, 2**CNT_W >= TICK_DIV
//
// Ports
//   ADC_CLK_10 : system clock
//   KEY0       : asynchronous active-low reset
//   hazard     : hazard request (highest priority)
//   turn_en    : turn request
//   turn_left  : 1 = left turn, 0 = right turn
//   brake      : brake request
//   lights_l   : left lamps, bit0 innermost
//   lights_r   : right lamps, bit0 innermost
//   mode       : 0 idle, 1 hazard, 2 left, 3 right, 4 brake,
//                5 left+brake, 6 right+brake
//   step       : one-cycle pulse on every sequence step
module taillight_sequencer #(
   parameter int unsigned TICK_DIV = 5000000,
   parameter int unsigned CNT_W    = 23
) (
   input  logic       ADC_CLK_10,
   input  logic       KEY0,
   input  logic       hazard,
   input  logic       turn_en,
   input  logic       turn_left,
   input  logic       brake,
   output logic [2:0] lights_l,
   output logic [2:0] lights_r,
   output logic [2:0] mode,
   output logic       step
);

   localparam logic [2:0] M_IDLE  = 3'd0;
   localparam logic [2:0] M_HAZ   = 3'd1;
   localparam logic [2:0] M_LEFT  = 3'd2;
   localparam logic [2:0] M_RIGHT = 3'd3;
   localparam logic [2:0] M_BRAKE = 3'd4;
   localparam logic [2:0] M_LBRK  = 3'd5;
   localparam logic [2:0] M_RBRK  = 3'd6;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_BRK     = 3'd1;
   localparam logic [2:0] ST_HAZ_OFF = 3'd2;
   localparam logic [2:0] ST_HAZ_ON  = 3'd3;
   localparam logic [2:0] ST_S0      = 3'd4;
   localparam logic [2:0] ST_S1      = 3'd5;
   localparam logic [2:0] ST_S2      = 3'd6;
   localparam logic [2:0] ST_S3      = 3'd7;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [2:0]       dmode;
   logic             chg;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [2:0]       state;
   logic [2:0]       state_nx;
   logic [2:0]       pat;
   logic [2:0]       brk_side;
   logic [2:0]       l_nx;
   logic [2:0]       r_nx;

   // Request decode, priority hazard > turn > brake > idle
   always_comb begin
      dmode = M_IDLE;
      if (hazard)
         dmode = M_HAZ;
      else if (turn_en)
         dmode = turn_left ? (brake ? M_LBRK : M_LEFT) : (brake ? M_RBRK : M_RIGHT);
      else if (brake)
         dmode = M_BRAKE;
   end

   assign chg = (dmode != mode);

   // Prescaler restarts on any mode change so the first step after a change
   // is a full TICK_DIV cycles away.
   always_comb begin
      if (chg || (cnt == CNT_LAST))
         cnt_nx = '0;
      else
         cnt_nx = cnt + CNT_W'(1);
   end

   // step is high exactly while cnt == CNT_LAST, so it also marks the edge
   // on which the sequence advances.
   always_comb begin
      state_nx = state;
      if (chg) begin
         case (dmode)
            M_IDLE:  state_nx = ST_IDLE;
            M_HAZ:   state_nx = ST_HAZ_OFF;
            M_BRAKE: state_nx = ST_BRK;
            default: state_nx = ST_S0;
         endcase
      end else if (step) begin
         case (state)
            ST_HAZ_OFF: state_nx = ST_HAZ_ON;
            ST_HAZ_ON:  state_nx = ST_HAZ_OFF;
            ST_S0:      state_nx = ST_S1;
            ST_S1:      state_nx = ST_S2;
            ST_S2:      state_nx = ST_S3;
            ST_S3:      state_nx = ST_S0;
            default:    state_nx = state;
         endcase
      end
   end

   // Lamp pattern from the next state so lights change on the same edge as mode
   always_comb begin
      case (state_nx)
         ST_S1:     pat = 3'b001;
         ST_S2:     pat = 3'b011;
         ST_S3:     pat = 3'b111;
         ST_HAZ_ON: pat = 3'b111;
         ST_BRK:    pat = 3'b111;
         default:   pat = 3'b000;
      endcase
      brk_side = ((dmode == M_LBRK) || (dmode == M_RBRK)) ? 3'b111 : 3'b000;
      case (dmode)
         M_LEFT, M_LBRK: begin
            l_nx = pat;
            r_nx = brk_side;
         end
         M_RIGHT, M_RBRK: begin
            l_nx = brk_side;
            r_nx = pat;
         end
         default: begin
            l_nx = pat;
            r_nx = pat;
         end
      endcase
   end

   always_ff @(posedge ADC_CLK_10 or negedge KEY0) begin
      if (!KEY0) begin
         mode     <= M_IDLE;
         cnt      <= '0;
         step     <= 1'b0;
         state    <= ST_IDLE;
         lights_l <= 3'b000;
         lights_r <= 3'b000;
      end else begin
         mode     <= dmode;
         cnt      <= cnt_nx;
         step     <= (cnt_nx == CNT_LAST);
         state    <= state_nx;
         lights_l <= l_nx;
         lights_r <= r_nx;
      end
   end

endmodule

// File: tb/tb_taillight_sequencer.sv
// tb_taillight_sequencer
//   Directed bench for taillight_sequencer with TICK_DIV=4. A table of
//   per-clock vectors covers hazard, left turn and right+brake with a mid-sweep
//   direction switch; hand sequences cover reset, steady brake, brake release
//   and an asynchronous reset during HAZ_ON.
module tb_taillight_sequencer;

   logic       clk;
   logic       key0;
   logic       hazard;
   logic       turn_en;
   logic       turn_left;
   logic       brake;
   logic [2:0] lights_l;
   logic [2:0] lights_r;
   logic [2:0] mode;
   logic       step;

   int unsigned checks;
   int unsigned failures;

   typedef struct {
      logic       h;
      logic       t;
      logic       tl;
      logic       b;
      logic [2:0] l;
      logic [2:0] r;
      logic [2:0] m;
      logic       s;
   } vec_t;

   vec_t vecs[$];

   taillight_sequencer #(
      .TICK_DIV(4),
      .CNT_W(3)
   ) dut (
      .ADC_CLK_10(clk),
      .KEY0(key0),
      .hazard(hazard),
      .turn_en(turn_en),
      .turn_left(turn_left),
      .brake(brake),
      .lights_l(lights_l),
      .lights_r(lights_r),
      .mode(mode),
      .step(step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int unsigned got, input int unsigned exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string nm, input logic [2:0] l, input logic [2:0] r,
                          input logic [2:0] m, input logic s);
      chk({nm, ".lights_l"}, lights_l, l);
      chk({nm, ".lights_r"}, lights_r, r);
      chk({nm, ".mode"}, mode, m);
      chk({nm, ".step"}, step, s);
   endtask

   task automatic add(input logic h, input logic t, input logic tl, input logic b,
                      input logic [2:0] l, input logic [2:0] r, input logic [2:0] m,
                      input logic s);
      vec_t v;
      v.h = h; v.t = t; v.tl = tl; v.b = b;
      v.l = l; v.r = r; v.m = m; v.s = s;
      vecs.push_back(v);
   endtask

   task automatic set_in(input logic h, input logic t, input logic tl, input logic b);
      hazard = h; turn_en = t; turn_left = tl; brake = b;
   endtask

   task automatic clk1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Hazard with every other request high (priority): 4 off, 4 on, ...
      for (int k = 0; k < 2; k++) begin
         add(1,1,1,1, 3'b000,3'b000,3'd1,0); add(1,1,1,1, 3'b000,3'b000,3'd1,0);
         add(1,1,1,1, 3'b000,3'b000,3'd1,0); add(1,1,1,1, 3'b000,3'b000,3'd1,1);
         add(1,1,1,1, 3'b111,3'b111,3'd1,0); add(1,1,1,1, 3'b111,3'b111,3'd1,0);
         add(1,1,1,1, 3'b111,3'b111,3'd1,0); add(1,1,1,1, 3'b111,3'b111,3'd1,1);
      end
      // Left turn sweep
      add(0,1,1,0, 3'b000,3'b000,3'd2,0); add(0,1,1,0, 3'b000,3'b000,3'd2,0);
      add(0,1,1,0, 3'b000,3'b000,3'd2,0); add(0,1,1,0, 3'b000,3'b000,3'd2,1);
      add(0,1,1,0, 3'b001,3'b000,3'd2,0); add(0,1,1,0, 3'b001,3'b000,3'd2,0);
      add(0,1,1,0, 3'b001,3'b000,3'd2,0); add(0,1,1,0, 3'b001,3'b000,3'd2,1);
      add(0,1,1,0, 3'b011,3'b000,3'd2,0); add(0,1,1,0, 3'b011,3'b000,3'd2,0);
      add(0,1,1,0, 3'b011,3'b000,3'd2,0); add(0,1,1,0, 3'b011,3'b000,3'd2,1);
      add(0,1,1,0, 3'b111,3'b000,3'd2,0); add(0,1,1,0, 3'b111,3'b000,3'd2,0);
      add(0,1,1,0, 3'b111,3'b000,3'd2,0); add(0,1,1,0, 3'b111,3'b000,3'd2,1);
      add(0,1,1,0, 3'b000,3'b000,3'd2,0);
      // Right + brake, then switch to left mid-sweep
      add(0,1,0,1, 3'b111,3'b000,3'd6,0); add(0,1,0,1, 3'b111,3'b000,3'd6,0);
      add(0,1,0,1, 3'b111,3'b000,3'd6,0); add(0,1,0,1, 3'b111,3'b000,3'd6,1);
      add(0,1,0,1, 3'b111,3'b001,3'd6,0); add(0,1,0,1, 3'b111,3'b001,3'd6,0);
      add(0,1,0,1, 3'b111,3'b001,3'd6,0); add(0,1,0,1, 3'b111,3'b001,3'd6,1);
      add(0,1,0,1, 3'b111,3'b011,3'd6,0); add(0,1,0,1, 3'b111,3'b011,3'd6,0);
      add(0,1,1,1, 3'b000,3'b111,3'd5,0); add(0,1,1,1, 3'b000,3'b111,3'd5,0);
      add(0,1,1,1, 3'b000,3'b111,3'd5,0); add(0,1,1,1, 3'b000,3'b111,3'd5,1);
      add(0,1,1,1, 3'b001,3'b111,3'd5,0);

      // Reset with all requests high
      key0 = 1'b0;
      set_in(1, 1, 1, 1);
      clk1();
      clk1();
      chk_all("reset", 3'b000, 3'b000, 3'd0, 1'b0);
      key0 = 1'b1;

      foreach (vecs[i]) begin
         set_in(vecs[i].h, vecs[i].t, vecs[i].tl, vecs[i].b);
         clk1();
         chk_all($sformatf("vec%0d", i), vecs[i].l, vecs[i].r, vecs[i].m, vecs[i].s);
      end

      // Steady brake for 20 clocks; prescaler still pulses step
      set_in(0, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         clk1();
         chk_all($sformatf("brake%0d", i), 3'b111, 3'b111, 3'd4, (i % 4) == 3);
      end
      set_in(0, 0, 0, 0);
      clk1();
      chk_all("idle", 3'b000, 3'b000, 3'd0, 1'b0);

      // Hazard with everything requested, then async reset in HAZ_ON
      set_in(1, 1, 0, 1);
      for (int i = 0; i < 5; i++) begin
         clk1();
         chk_all($sformatf("prio%0d", i), (i == 4) ? 3'b111 : 3'b000,
                 (i == 4) ? 3'b111 : 3'b000, 3'd1, i == 3);
      end
      #2;
      key0 = 1'b0;
      #1;
      chk_all("async_rst", 3'b000, 3'b000, 3'd0, 1'b0);
      clk1();
      chk_all("rst_hold", 3'b000, 3'b000, 3'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
